uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 14 +
 rtl/uart_tx_arb_rr.sv | 28 ++
 rtl/uart_tx_arb.sv | 123 ++++++++++++
 tb/tb_uart_tx_arb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the uart_tx_arb slice: state encoding and default lock timeout.
package uart_tx_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    LOCK = ST_LOCK
  } state_e;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1024;

endpackage

// File: rtl/uart_tx_arb_rr.sv
// Combinational round-robin picker: first valid requester strictly after ptr_i, wrapping.
module uart_tx_arb_rr #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            found_o
);

  logic [PW-1:0] idx;

  // Offset k=NREQ lands back on ptr_i itself, so the last owner wins only when alone.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_i) + k) % NREQ);
      if (!found_o && valid_i[idx]) begin
        winner_o[idx] = 1'b1;
        found_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter sharing one uart_tx between NREQ byte streams.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] winner;
  logic            found;
  logic [PW-1:0]   g_idx;
  logic            valid_g, last_g, handshake;
  logic [7:0]      data_masked [NREQ];
  logic [7:0]      mux_data;

  uart_tx_arb_rr #(.NREQ(NREQ), .PW(PW)) u_rr (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
    assign data_masked[gi] = grant_q[gi] ? req_data_i[8*gi +: 8] : 8'h00;
  end

  always_comb begin
    mux_data = 8'h00;
    g_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      mux_data = mux_data | data_masked[k];
      if (grant_q[k]) g_idx = PW'(k);
    end
  end

  assign busy_o      = (state_q == LOCK);
  assign grant_o     = grant_q;
  assign timeout_o   = timeout_q;
  assign valid_g     = |(req_valid_i & grant_q);
  assign last_g      = |(req_last_i & grant_q);
  assign tx_valid_o  = busy_o & valid_g;
  assign tx_data_o   = busy_o ? mux_data : 8'h00;
  assign req_ready_o = grant_q & {NREQ{busy_o & tx_ready_i}};
  assign handshake   = tx_valid_o & tx_ready_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && found) begin
          state_d = LOCK;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        // en_i is deliberately ignored here: a started packet always runs to last or timeout.
        if (handshake) begin
          cnt_d = '0;
          if (last_g) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = g_idx;
          end
        end else if (!valid_g) begin
          if (cnt_q >= TIMEOUT - 16'd1) begin
            state_d   = IDLE;
            grant_d   = '0;
            ptr_d     = g_idx;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PW'(NREQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: round-robin order, multi-byte lock, timeout, stall, enable, reset.
module tb_uart_tx_arb;

  localparam int          NREQ = 4;
  localparam logic [15:0] TMO  = 16'd8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [3:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic tv,
                         input logic [7:0] d, input logic [3:0] rdy,
                         input logic b, input logic tmo);
    #1;
    $display("%0t %s grant=%b tx_valid=%b tx_data=%h ready=%b busy=%b timeout=%b",
             $time, tag, grant_o, tx_valid_o, tx_data_o, req_ready_o, busy_o, timeout_o);
    chk({tag, ".grant"},   32'(grant_o),     32'(g));
    chk({tag, ".tx_valid"}, 32'(tx_valid_o), 32'(tv));
    chk({tag, ".tx_data"},  32'(tx_data_o),  32'(d));
    chk({tag, ".ready"},    32'(req_ready_o), 32'(rdy));
    chk({tag, ".busy"},     32'(busy_o),     32'(b));
    chk({tag, ".timeout"},  32'(timeout_o),  32'(tmo));
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; req_valid_i = '0; req_last_i = '0;
    req_data_i = '0; tx_ready_i = 1'b1;
    cyc(); cyc();
    chk_out("rst", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    req_valid_i = 4'b1111;
    chk_out("rst_req", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Single-byte packets from requesters 1 and 3 alternate, starting at 1.
    req_valid_i = 4'b1010; req_last_i = 4'b1111; req_data_i = 32'h33_22_11_00;
    rst_i = 1'b0;
    chk_out("rr_idle0", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    cyc(); chk_out("rr_g1a",  4'b0010, 1, 8'h11, 4'b0010, 1, 0);
    cyc(); chk_out("rr_rel1", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    cyc(); chk_out("rr_g3",   4'b1000, 1, 8'h33, 4'b1000, 1, 0);
    cyc(); chk_out("rr_rel3", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    cyc(); chk_out("rr_g1b",  4'b0010, 1, 8'h11, 4'b0010, 1, 0);
    cyc(); req_valid_i = '0;
    chk_out("rr_rel1b", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Three-byte packet from requester 2 while requester 0 waits.
    req_valid_i = 4'b0101; req_last_i = 4'b0001; req_data_i = 32'h00_41_00_A0;
    cyc(); chk_out("pkt_b0", 4'b0100, 1, 8'h41, 4'b0100, 1, 0);
    cyc(); req_data_i[23:16] = 8'h42;
    chk_out("pkt_b1", 4'b0100, 1, 8'h42, 4'b0100, 1, 0);
    cyc(); req_data_i[23:16] = 8'h43; req_last_i[2] = 1'b1;
    chk_out("pkt_b2", 4'b0100, 1, 8'h43, 4'b0100, 1, 0);
    cyc(); req_valid_i[2] = 1'b0;
    chk_out("pkt_rel", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    cyc(); chk_out("pkt_next0", 4'b0001, 1, 8'hA0, 4'b0001, 1, 0);
    cyc(); req_valid_i = '0;
    chk_out("pkt_rel0", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Requester 1 stalls mid-packet; lock revoked 8 edges after its handshake.
    req_valid_i = 4'b1010; req_last_i = 4'b1000; req_data_i = 32'h99_00_77_00;
    cyc(); chk_out("tmo_hs", 4'b0010, 1, 8'h77, 4'b0010, 1, 0);
    cyc(); req_valid_i[1] = 1'b0;
    chk_out("tmo_wait1", 4'b0010, 0, 8'h77, 4'b0010, 1, 0);
    for (int i = 2; i <= 8; i++) begin
      cyc(); chk_out($sformatf("tmo_wait%0d", i), 4'b0010, 0, 8'h77, 4'b0010, 1, 0);
    end
    cyc(); chk_out("tmo_pulse", 4'b0000, 0, 8'h00, 4'b0000, 0, 1);
    cyc(); chk_out("tmo_next3", 4'b1000, 1, 8'h99, 4'b1000, 1, 0);
    cyc(); req_valid_i = '0;
    chk_out("tmo_rel3", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // uart_tx back-pressure for 20 cycles with valid held high.
    req_valid_i = 4'b0010; req_last_i = 4'b0010; req_data_i = 32'h00_00_5A_00;
    tx_ready_i = 1'b0;
    cyc(); chk_out("stall0", 4'b0010, 1, 8'h5A, 4'b0000, 1, 0);
    for (int i = 1; i < 20; i++) begin
      cyc(); chk_out($sformatf("stall%0d", i), 4'b0010, 1, 8'h5A, 4'b0000, 1, 0);
    end
    tx_ready_i = 1'b1;
    chk_out("stall_go", 4'b0010, 1, 8'h5A, 4'b0010, 1, 0);
    cyc(); req_valid_i = '0;
    chk_out("stall_rel", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);

    // Enable gating: no grant while low, but an active packet finishes.
    en_i = 1'b0; req_valid_i = 4'b0001; req_last_i = 4'b0000; req_data_i = 32'h00_00_00_C1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_out($sformatf("en_off%0d", i), 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    end
    en_i = 1'b1;
    cyc(); en_i = 1'b0;
    chk_out("en_lock_b0", 4'b0001, 1, 8'hC1, 4'b0001, 1, 0);
    cyc(); req_data_i[7:0] = 8'hC2; req_last_i[0] = 1'b1;
    chk_out("en_lock_b1", 4'b0001, 1, 8'hC2, 4'b0001, 1, 0);
    cyc(); chk_out("en_done", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_out($sformatf("en_hold%0d", i), 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    end

    // Asynchronous reset in the middle of a packet from requester 2.
    en_i = 1'b1; req_valid_i = 4'b0100; req_last_i = 4'b0001; req_data_i = 32'h00_D4_00_E0;
    cyc(); chk_out("rstm_b0", 4'b0100, 1, 8'hD4, 4'b0100, 1, 0);
    cyc(); chk_out("rstm_b1", 4'b0100, 1, 8'hD4, 4'b0100, 1, 0);
    rst_i = 1'b1;
    chk_out("rstm_rst", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    req_valid_i = 4'b0101;
    cyc(); chk_out("rstm_hold", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    rst_i = 1'b0;
    cyc(); chk_out("rstm_win0", 4'b0001, 1, 8'hE0, 4'b0001, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
